// File: rtl/cpu_defines.sv
// Shared definitions for the CPU-to-AXI bridge.
//   SIZE_*       : CPU access size encodings (byte/half/word)
//   AXI_ID_*     : AR transaction IDs used to route read data back to a port
//   rd_state_e   : read-path FSM states
//   wr_state_e   : write-path FSM states
package cpu_defines;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] AXI_ID_INST = 4'd0;
  localparam logic [3:0] AXI_ID_DATA = 4'd1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe generator for single-beat 32-bit stores.
// Ports:
//   size_i    : access size (byte/half/word)
//   addr_lo_i : low two bits of the byte address
//   wstrb_o   : AXI write strobe for the addressed lanes
module axi_wstrb_gen (
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] wstrb_o
);
  import cpu_defines::*;

  always_comb begin
    wstrb_o = 4'b0000;
    case (size_i)
      SIZE_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
      SIZE_HALF: wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: wstrb_o = 4'b1111;
      // Size 3 is never issued by the CPU; no lanes are enabled.
      default:   wstrb_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridge from the CPU's SRAM-like inst/data ports to one 32-bit AXI3 master.
// Each request becomes a single-beat AXI read or write. One read and one write
// may be outstanding at a time; a data read has priority over an inst read.
// Ports:
//   clk, resetn                 : clock, synchronous active-low reset
//   inst_*                      : instruction fetch port (read only)
//   data_*                      : load/store port
//   ar*/r*                      : AXI read address / read data channels
//   aw*/w*/b*                   : AXI write address / data / response channels
//   (len/burst/lock/cache/prot/awid/wid/wlast are constant tie-offs)
module cpu_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // inst port
  input  logic              inst_req,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data port
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // AR channel
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  // R channel
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  // AW channel
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  // W channel
  output logic [3:0]        wid,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // B channel
  input  logic              bvalid,
  output logic              bready
);
  import cpu_defines::*;

  rd_state_e         r_state_q, r_state_d;
  wr_state_e         w_state_q, w_state_d;

  logic [3:0]        ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [1:0]        ar_size_q;

  logic [ADDR_W-1:0] aw_addr_q;
  logic [1:0]        aw_size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [3:0]        wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic              inst_data_ok_q, inst_data_ok_d;
  logic              data_data_ok_q, data_data_ok_d;
  logic [DATA_W-1:0] rdata_q;

  logic              rd_data_acc, rd_inst_acc, wr_acc;
  logic              data_rd_busy;
  logic              rd_hit;

  axi_wstrb_gen u_wstrb (
    .size_i    (data_size),
    .addr_lo_i (data_addr[1:0]),
    .wstrb_o   (wstrb_d)
  );

  // A data read is still outstanding; a store must not overtake it.
  assign data_rd_busy = (r_state_q != R_IDLE) && (ar_id_q == AXI_ID_DATA);
  assign rd_hit       = (r_state_q == R_R) && rvalid;

  // Read FSM: next state and acceptance. Acceptance is gated by resetn so no
  // addr_ok is shown while reset is held.
  always_comb begin
    r_state_d   = r_state_q;
    rd_data_acc = 1'b0;
    rd_inst_acc = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (resetn) begin
          // Loads wait for an in-progress store so they observe its data.
          if (data_req && !data_wr && (w_state_q == W_IDLE)) begin
            rd_data_acc = 1'b1;
            r_state_d   = R_AR;
          end else if (inst_req) begin
            rd_inst_acc = 1'b1;
            r_state_d   = R_AR;
          end
        end
      end
      R_AR:    if (arready) r_state_d = R_R;
      R_R:     if (rvalid)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM: AW and W complete independently; each done flag remembers
  // its own handshake until both have happened.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_acc    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (resetn && data_req && data_wr && !data_rd_busy) begin
          wr_acc    = 1'b1;
          w_state_d = W_REQ;
        end
      end
      W_REQ: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
          w_state_d = W_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_B:     if (bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read data and write responses never coincide on the data port: a load
  // cannot start during a store and a store cannot start during a load.
  always_comb begin
    inst_data_ok_d = rd_hit && (rid == AXI_ID_INST);
    data_data_ok_d = (rd_hit && (rid == AXI_ID_DATA)) ||
                     ((w_state_q == W_B) && bvalid);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q      <= R_IDLE;
      w_state_q      <= W_IDLE;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
    end else begin
      r_state_q      <= r_state_d;
      w_state_q      <= w_state_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_data_ok_q <= data_data_ok_d;
    end
  end

  // Request payloads are only meaningful while their FSM is busy, so they
  // need no reset.
  always_ff @(posedge clk) begin
    if (rd_data_acc) begin
      ar_id_q   <= AXI_ID_DATA;
      ar_addr_q <= data_addr;
      ar_size_q <= data_size;
    end else if (rd_inst_acc) begin
      ar_id_q   <= AXI_ID_INST;
      ar_addr_q <= inst_addr;
      ar_size_q <= inst_size;
    end
    if (wr_acc) begin
      aw_addr_q <= data_addr;
      aw_size_q <= data_size;
      wdata_q   <= data_wdata;
      wstrb_q   <= wstrb_d;
    end
    if (rd_hit) rdata_q <= rdata;
  end

  // CPU side
  assign inst_addr_ok = rd_inst_acc;
  assign data_addr_ok = rd_data_acc | wr_acc;
  assign inst_data_ok = inst_data_ok_q;
  assign data_data_ok = data_data_ok_q;
  assign inst_rdata   = rdata_q;
  assign data_rdata   = rdata_q;

  // AXI read side
  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = {1'b0, ar_size_q};
  assign arvalid = (r_state_q == R_AR);
  assign rready  = (r_state_q == R_R);
  assign arlen   = 4'd0;
  assign arburst = 2'd1;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  // AXI write side
  assign awid    = 4'd1;
  assign awaddr  = aw_addr_q;
  assign awsize  = {1'b0, aw_size_q};
  assign awvalid = (w_state_q == W_REQ) && !aw_done_q;
  assign awlen   = 4'd0;
  assign awburst = 2'd1;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = 4'd1;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (w_state_q == W_REQ) && !w_done_q;
  assign bready  = (w_state_q == W_B);

endmodule
